serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are WIDTH >= 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: operation request, sampled at a rising edge.
REQ-005 Port a, input, WIDTH bits: first operand.
REQ-006 Port b, input, WIDTH bits: second operand.
REQ-007 Port cin, input, 1 bit: carry-in.
REQ-008 Port ready, output, 1 bit: high when the block can accept start.
REQ-009 Port busy, output, 1 bit: high while bits are being processed.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 Port sum, output, WIDTH bits: registered result sum.
REQ-012 Port carry, output, 1 bit: registered result carry-out.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-014 Outputs SHALL decode from state only: ready = (state==IDLE); busy = (state==BUSY); done = (state==DONE).
REQ-015 Acceptance SHALL occur only at an edge where state==IDLE and start==1.
REQ-016 Acceptance SHALL capture a, b and cin into internal shift/carry registers, clear the bit counter, and move the FSM to BUSY.
REQ-017 Start SHALL be ignored in BUSY and DONE; no queuing.
REQ-018 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-019 Each BUSY cycle SHALL process one bit, LSB first, through a 1-bit full-adder cell:
  - bit = a0 ^ b0 ^ c
  - c_next = majority(a0, b0, c)
REQ-020 Each BUSY cycle SHALL shift both operand registers right by one.
REQ-021 Each BUSY cycle SHALL shift the result bit into the MSB of the internal sum register, shifting it right.
REQ-022 BUSY SHALL last exactly WIDTH cycles.
REQ-023 After the WIDTH-th bit, the FSM SHALL enter DONE, and sum and carry SHALL load the full WIDTH-bit sum and the final carry.
REQ-024 Timing: with acceptance at edge k, busy SHALL be high for edges k+1..k+WIDTH, done SHALL be high between edges k+WIDTH and k+WIDTH+1, and ready SHALL be high again from edge k+WIDTH+1.
REQ-025 Latency from accept edge to done SHALL be WIDTH cycles; throughput SHALL be one operation per WIDTH+2 cycles with start held high.
REQ-026 DONE SHALL always return to IDLE after one cycle.
REQ-027 Arithmetic: {carry, sum} SHALL equal a + b + cin as a (WIDTH+1)-bit value; no overflow is possible.
REQ-028 sum and carry SHALL hold the last result until the next DONE; they SHALL NOT change during BUSY.
REQ-029 The bit counter SHALL be $clog2(WIDTH+1) bits and SHALL NOT wrap within an operation.

Reset
REQ-030 rst_n low SHALL immediately force:
  - state = IDLE
  - sum = 0, carry = 0
  - internal operand, carry and counter registers = 0
  - ready = 1, busy = 0, done = 0
REQ-031 Reset asserted mid-operation SHALL abort the operation and leave no partial result on sum or carry.
REQ-032 After rst_n deasserts, the first edge with start==1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-033 Accept a=0, b=0, cin=0 -> done 8 cycles after accept; sum=0x00, carry=0.
REQ-034 Accept a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1.
REQ-035 Accept a=0xC8, b=0x64, cin=0 -> sum=0x2C, carry=1.
REQ-036 Accept a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
REQ-037 Accept a=0x0F, b=0x01; pulse start with a=0xAA during BUSY; change a and b mid-BUSY -> result still sum=0x10, carry=0, exactly one done pulse; ready rises one cycle after done.
REQ-038 Accept a=0xFF, b=0xFF; assert rst_n low at BUSY cycle 4 -> outputs immediately 0 with ready=1, no done pulse; next accept of a=3, b=4 -> sum=0x07, carry=0.

Source files
------------

// File: rtl/serial_adder.sv
// Purpose : bit-serial WIDTH-bit adder, {carry, sum} = a + b + cin, one bit per cycle LSB first.
// Latency : WIDTH cycles from accept edge to done; one operation per WIDTH+2 cycles with start held.
// Backpressure: start is honoured only while ready; start in BUSY/DONE is dropped, never queued.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, a, b, cin   operation request and operands, captured on acceptance
//   ready, busy, done  state decode: idle / processing bits / one-cycle result-valid pulse
//   sum, carry         registered result, held until the next done
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic             fa_bit;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  // One full-adder cell shared by every bit position.
  assign fa_bit = a_sh[0] ^ b_sh[0] ^ c_q;
  assign fa_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_q) | (b_sh[0] & c_q);
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign s_next = {fa_bit, s_sh[WIDTH-1:1]};

  assign ready = (state == IDLE);
  assign busy  = (state == BUSY);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            c_q   <= cin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_next;
          c_q  <= fa_c;
          // sum/carry only change here, so they hold through the whole BUSY phase.
          if (cnt == LAST) begin
            sum   <= s_next;
            carry <= fa_c;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  int n_cmp;
  int n_fail;

  logic [WIDTH-1:0] prev_sum;
  logic             prev_carry;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks the full cycle-by-cycle timeline.
  // disturb: pulses start and changes operands mid-BUSY, and holds start during DONE.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec,
                        input bit disturb);
    int dones;
    dones = 0;
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();                       // accept edge k
    start = 1'b0;
    check({tag, "_acc_busy"},  busy,  1);
    check({tag, "_acc_ready"}, ready, 0);
    for (int i = 1; i < WIDTH; i++) begin
      if (disturb && i == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      end
      if (disturb && i == 5) start = 1'b0;
      tick();                     // edges k+1 .. k+WIDTH-1
      if (done) dones++;
      check({tag, "_busy"},      busy,  1);
      check({tag, "_hold_sum"},  sum,   prev_sum);
      check({tag, "_hold_cry"},  carry, prev_carry);
    end
    tick();                       // edge k+WIDTH
    if (done) dones++;
    check({tag, "_done"},       done,  1);
    check({tag, "_done_busy"},  busy,  0);
    check({tag, "_done_ready"}, ready, 0);
    check({tag, "_sum"},        sum,   es);
    check({tag, "_carry"},      carry, ec);
    if (disturb) start = 1'b1;
    tick();                       // edge k+WIDTH+1
    start = 1'b0;
    if (done) dones++;
    check({tag, "_idle_ready"}, ready, 1);
    check({tag, "_idle_busy"},  busy,  0);
    check({tag, "_idle_sum"},   sum,   es);
    check({tag, "_ndone"},      dones, 1);
    prev_sum   = es;
    prev_carry = ec;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    prev_sum = '0; prev_carry = 1'b0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_sum",   sum,   0);
    check("rst_carry", carry, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", ready, 1);

    run_op("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("c8_64", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
    run_op("ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("5a_a5", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    run_op("dist",  8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);

    // Reset in the middle of an operation.
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy",  busy,  0);
    check("mid_rst_done",  done,  0);
    check("mid_rst_sum",   sum,   0);
    check("mid_rst_carry", carry, 0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      check("rst_hold_done", done, 0);
    end
    rst_n = 1'b1;
    prev_sum = '0; prev_carry = 1'b0;
    run_op("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
